uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Parametrised UART receive core: the next generation of the receive control FSM. It integrates the input synchroniser, edge and bit counters, 3-sample majority voting, the deserialiser and the start, parity and stop checkers in one block. It adds configurable data width, even/odd parity, 1 or 2 stop bits and per-frame configuration latching. It sits between the RX pad and the system-side register/FIFO, clocked at prescale × baud.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9 legal)
PRESCALE_W, 6, width of prescale input; max oversampling 2^PRESCALE_W-2

Ports:
clk  in  1  oversampling clock (prescale × baud)
rst  in  1  asynchronous, active-low reset
rx_in  in  1  asynchronous serial line, idle high
prescale  in  PRESCALE_W  clocks per bit; LSB ignored (forced even); values <8 treated as 8
par_en  in  1  1 = parity bit present
par_type  in  1  0 = even, 1 = odd
stop_bits2  in  1  1 = two stop bits
p_data  out  DATA_WIDTH  last good frame payload, LSB first on line
data_valid  out  1  1-cycle pulse, p_data updated same cycle
par_err  out  1  1-cycle pulse on parity mismatch
stop_err  out  1  1-cycle pulse on framing error
start_glitch  out  1  1-cycle pulse when the start bit votes high
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, active-low): state IDLE, all counters 0, synchroniser flops = 1, p_data = 0, all outputs 0.
- rx_in passes through a 2-flop synchroniser giving rx_s (2-cycle latency). All logic uses rx_s only.
- Config latch: prescale (normalised), par_en, par_type and stop_bits2 are captured on the IDLE→START transition. Input changes mid-frame are ignored.
- Let P = latched prescale and h = P/2.
- Edge counter: 0..P-1, wraps to 0 at P-1. It is cleared on entry to START. Bit counter advances on each wrap.
- Sampling: rx_s is sampled at edge_cnt = h-1, h, h+1. The majority vote is valid at edge_cnt = h+2, the decision point D.
- Five states:
  - IDLE: on rx_s == 0, go to START next cycle with edge_cnt = 0.
  - START: at D, vote = 1 → start_glitch pulse, go to IDLE. Otherwise at edge_cnt = P-1, go to DATA.
  - DATA: at D, shift the vote into the shift register (LSB first). At P-1 of bit DATA_WIDTH-1, go to PARITY if par_en, else to STOP.
  - PARITY: at D, check the XOR of the shift register and the vote: nonzero (even) or zero (odd) → par_err pulse, frame marked bad. The FSM always continues to STOP at P-1 to keep alignment.
  - STOP: at D, vote = 0 → stop_err pulse, go to IDLE.
    - Vote = 1 with stop_bits2 = 1 on the first stop bit → wait until P-1, then re-enter STOP for the second stop bit.
    - Final stop bit good → data_valid pulse and p_data load, unless the frame is marked bad. Go to IDLE at D+1, with no wait to end of bit, so a start edge in the second half of the stop bit is caught.
- par_err and stop_err in the same frame: both pulse, each at its own decision cycle. data_valid is suppressed.
- p_data holds its value between valid frames and is never loaded from a bad frame.
- Latency (P = 8, 8N1): data_valid fires 9P + h + 2 = 78 cycles after START entry.
- Back-to-back frames: a line low seen in IDLE immediately after STOP starts a new frame with no dead cycle.
- Reset mid-frame: immediate return to IDLE. No pulses are emitted on or after reset release until a new frame completes.

Test Plan:
- P=8, 8N1, send 0xA5 → data_valid single pulse 78 cycles after START entry, p_data = 0xA5, no error pulses.
- P=16, 8E1, send 0x3C with a wrong parity bit → par_err pulse at the parity D point, no data_valid, p_data keeps its previous value, FSM returns to IDLE after the stop bit.
- P=8, 8O2, send 0x81 with the second stop bit low → stop_err pulse at the second stop D point, no data_valid, busy falls the next cycle.
- Low glitch of 2 clocks on idle line → START entered, start_glitch pulse at edge_cnt = 6, back to IDLE, no data_valid.
- Two back-to-back 8N1 frames 0x00 then 0xFF, each with one stop bit → two data_valid pulses exactly 10P cycles apart, p_data = 0x00 then 0xFF.
- Assert rst mid-DATA, then change prescale from 8 to 16 during the next frame's DATA phase → all outputs 0 during reset; the frame decodes correctly at P=8 (latched value).

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive core: synchroniser, 3-sample majority vote, deserialiser and
// start/parity/stop checking. Frame format is captured at the start edge and
// held for the whole frame.
`timescale 1ns/1ps
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  stop_bits2,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  start_glitch,
  output logic                  busy
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Current FSM state; kept as a named enum so checkers can bind to it.
  state_t state;

  logic                  rx_meta;
  logic                  rx_s;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] p_lat;
  logic                  pen_l;
  logic                  ptype_l;
  logic                  st2_l;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  s0;
  logic                  s1;
  logic                  vote_r;
  logic                  frame_bad;
  logic                  stop_second;

  logic [PRESCALE_W-1:0] presc_even;
  logic [PRESCALE_W-1:0] presc_norm;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] cnt_s0;
  logic [PRESCALE_W-1:0] cnt_s1;
  logic [PRESCALE_W-1:0] cnt_dec;
  logic [PRESCALE_W-1:0] cnt_d;
  logic [PRESCALE_W-1:0] cnt_end;
  logic                  vote_now;
  logic                  last_stop;

  // Prescale is forced even and clamped to a minimum of 8 before latching.
  assign presc_even = prescale & ~PRESCALE_W'(1);
  assign presc_norm = (presc_even < PRESCALE_W'(8)) ? PRESCALE_W'(8) : presc_even;

  // Sample points h-1, h, h+1. The vote is formed in the h+1 cycle from the
  // two stored samples plus the live third one, so its registered effects
  // (pulses, shift, p_data) become visible exactly at the decision point h+2.
  assign half     = {1'b0, p_lat[PRESCALE_W-1:1]};
  assign cnt_s0   = half - PRESCALE_W'(1);
  assign cnt_s1   = half;
  assign cnt_dec  = half + PRESCALE_W'(1);
  assign cnt_d    = half + PRESCALE_W'(2);
  assign cnt_end  = p_lat - PRESCALE_W'(1);
  assign vote_now = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign last_stop = !st2_l || stop_second;

  assign busy = (state != S_IDLE);

  // Two-flop synchroniser on the raw line; resets to the idle (high) level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with edge/bit counters, voting, deserialiser and checkers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      edge_cnt     <= '0;
      p_lat        <= '0;
      pen_l        <= 1'b0;
      ptype_l      <= 1'b0;
      st2_l        <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      s0           <= 1'b0;
      s1           <= 1'b0;
      vote_r       <= 1'b0;
      frame_bad    <= 1'b0;
      stop_second  <= 1'b0;
      p_data       <= '0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stop_err     <= 1'b0;
      start_glitch <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stop_err     <= 1'b0;
      start_glitch <= 1'b0;

      if (state != S_IDLE) begin
        if (edge_cnt == cnt_end) edge_cnt <= '0;
        else                     edge_cnt <= edge_cnt + PRESCALE_W'(1);
        if (edge_cnt == cnt_s0)  s0 <= rx_s;
        if (edge_cnt == cnt_s1)  s1 <= rx_s;
        if (edge_cnt == cnt_dec) vote_r <= vote_now;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state       <= S_START;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            frame_bad   <= 1'b0;
            stop_second <= 1'b0;
            p_lat       <= presc_norm;
            pen_l       <= par_en;
            ptype_l     <= par_type;
            st2_l       <= stop_bits2;
          end
        end

        S_START: begin
          if (edge_cnt == cnt_dec && vote_now) start_glitch <= 1'b1;
          if (edge_cnt == cnt_d && vote_r) begin
            state    <= S_IDLE;
            edge_cnt <= '0;
          end else if (edge_cnt == cnt_end) begin
            state <= S_DATA;
          end
        end

        S_DATA: begin
          if (edge_cnt == cnt_dec) shreg <= {vote_now, shreg[DATA_WIDTH-1:1]};
          if (edge_cnt == cnt_end) begin
            if (bit_cnt == LAST_BIT) state <= pen_l ? S_PARITY : S_STOP;
            else                     bit_cnt <= bit_cnt + BCW'(1);
          end
        end

        S_PARITY: begin
          // Even: any odd total is an error; odd: any even total is an error.
          if (edge_cnt == cnt_dec && ((^shreg) ^ vote_now ^ ptype_l)) begin
            par_err   <= 1'b1;
            frame_bad <= 1'b1;
          end
          if (edge_cnt == cnt_end) state <= S_STOP;
        end

        S_STOP: begin
          if (edge_cnt == cnt_dec) begin
            if (!vote_now) begin
              stop_err <= 1'b1;
            end else if (last_stop && !frame_bad) begin
              data_valid <= 1'b1;
              p_data     <= shreg;
            end
          end
          // Leave right after the decision so a following start edge in the
          // second half of the stop bit is not missed.
          if (edge_cnt == cnt_d && (!vote_r || last_stop)) begin
            state    <= S_IDLE;
            edge_cnt <= '0;
          end
          if (edge_cnt == cnt_end) stop_second <= 1'b1;
        end

        default: begin
          state    <= S_IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a table of frames with expected pulse counts and
// timing, plus hand-written glitch, back-to-back and mid-frame reset cases.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_type;
  logic       stop_bits2;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stop_err;
  logic       start_glitch;
  logic       busy;

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
    .par_en(par_en), .par_type(par_type), .stop_bits2(stop_bits2),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err),
    .stop_err(stop_err), .start_glitch(start_glitch), .busy(busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good;

  int dv_n = 0, pe_n = 0, se_n = 0, sg_n = 0;
  int dv_cyc = 0, dv_prev = 0, pe_cyc = 0, se_cyc = 0, sg_cyc = 0;
  int start_cyc = 0, idle_cyc = 0;
  logic busy_q = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         pin;      // value driven on prescale
    int         p;        // bit period on the line
    logic       pen;
    logic       ptype;
    logic       st2;
    logic       bad_par;
    logic       stop1;
    logic       stop2v;
    int         chg_bit;  // data bit at which prescale is changed to 16
    int         exp_dv;
    int         exp_pe;
    int         exp_se;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input int pin, input int p,
                              input logic pen, input logic ptype, input logic st2,
                              input logic bad_par, input logic s1, input logic s2,
                              input int edv, input int epe, input int ese);
    vec_t v;
    v.data = d; v.pin = pin; v.p = p; v.pen = pen; v.ptype = ptype; v.st2 = st2;
    v.bad_par = bad_par; v.stop1 = s1; v.stop2v = s2; v.chg_bit = -1;
    v.exp_dv = edv; v.exp_pe = epe; v.exp_se = ese;
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_q = 1'b0;
      end else begin
        if (busy && !busy_q) start_cyc = cyc;
        if (!busy && busy_q) idle_cyc = cyc;
        busy_q = busy;
        if (data_valid) begin
          dv_n++;
          dv_prev = dv_cyc;
          dv_cyc  = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dv_unexpected: p_data=0x%0h, expected no data_valid", p_data);
          end else begin
            chk("sb_p_data", p_data, exp_q.pop_front());
          end
        end
        if (par_err)      begin pe_n++; pe_cyc = cyc; end
        if (stop_err)     begin se_n++; se_cyc = cyc; end
        if (start_glitch) begin sg_n++; sg_cyc = cyc; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input int p);
    rx_in = b;
    repeat (p) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v);
    send_bit(1'b0, v.p);
    for (int i = 0; i < 8; i++) begin
      if (i == v.chg_bit) prescale = 6'd16;
      send_bit(v.data[i], v.p);
    end
    if (v.pen) send_bit((^v.data) ^ v.ptype ^ v.bad_par, v.p);
    send_bit(v.stop1, v.p);
    if (v.st2) send_bit(v.stop2v, v.p);
    rx_in = 1'b1;
  endtask

  task automatic set_cfg(input vec_t v);
    prescale   = 6'(v.pin);
    par_en     = v.pen;
    par_type   = v.ptype;
    stop_bits2 = v.st2;
  endtask

  task automatic run_vec(input vec_t v);
    int dv0, pe0, se0, sg0, h, base, lat_dv, lat_pe, lat_se;
    @(posedge clk); #1;
    set_cfg(v);
    dv0 = dv_n; pe0 = pe_n; se0 = se_n; sg0 = sg_n;
    if (v.exp_dv != 0) begin
      exp_q.push_back(v.data);
      last_good = v.data;
    end
    send_frame(v);
    repeat (2 * v.p) @(posedge clk);
    #1;
    h      = v.p / 2;
    base   = 9 + (v.pen ? 1 : 0);
    lat_dv = (base + (v.st2 ? 1 : 0)) * v.p + h + 2;
    lat_pe = 9 * v.p + h + 2;
    lat_se = (v.stop1 ? base + 1 : base) * v.p + h + 2;
    chk("dv_count", dv_n - dv0, v.exp_dv);
    chk("pe_count", pe_n - pe0, v.exp_pe);
    chk("se_count", se_n - se0, v.exp_se);
    chk("sg_count", sg_n - sg0, 0);
    chk("p_data_hold", p_data, last_good);
    chk("busy_idle", busy, 0);
    if (v.exp_dv != 0) chk("dv_latency", dv_cyc - start_cyc, lat_dv);
    if (v.exp_pe != 0) chk("pe_latency", pe_cyc - start_cyc, lat_pe);
    if (v.exp_se != 0) begin
      chk("se_latency", se_cyc - start_cyc, lat_se);
      chk("se_busy_fall", idle_cyc - se_cyc, 1);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int dv0, pe0, se0, sg0;
    vec_t v;

    rst = 1'b0; rx_in = 1'b1; prescale = 6'd8;
    par_en = 1'b0; par_type = 1'b0; stop_bits2 = 1'b0;
    last_good = 8'h00;

    //            data  pin  p  pen ptp st2 bpar s1 s2  dv pe se
    vecs.push_back(mk(8'hA5,  8,  8, 0, 0, 0, 0, 1, 1,  1, 0, 0)); // 8N1
    vecs.push_back(mk(8'h3C, 16, 16, 1, 0, 0, 1, 1, 1,  0, 1, 0)); // 8E1 bad parity
    vecs.push_back(mk(8'h81,  8,  8, 1, 1, 1, 0, 1, 0,  0, 0, 1)); // 8O2 2nd stop low
    vecs.push_back(mk(8'h5A,  8,  8, 1, 1, 0, 0, 1, 1,  1, 0, 0)); // 8O1
    vecs.push_back(mk(8'hC3, 12, 12, 1, 0, 1, 0, 1, 1,  1, 0, 0)); // 8E2
    vecs.push_back(mk(8'h7E,  9,  8, 0, 0, 0, 0, 1, 1,  1, 0, 0)); // odd prescale
    vecs.push_back(mk(8'h0F,  4,  8, 0, 0, 0, 0, 1, 1,  1, 0, 0)); // prescale < 8
    vecs.push_back(mk(8'h99,  8,  8, 1, 0, 0, 0, 0, 1,  0, 0, 1)); // 8E1 stop low
    vecs.push_back(mk(8'h24,  8,  8, 1, 1, 0, 1, 0, 1,  0, 1, 1)); // both errors
    vecs.push_back(mk(8'h42,  8,  8, 0, 0, 1, 0, 0, 1,  0, 0, 1)); // 8N2 1st stop low
    for (int i = 0; i < 4; i++) begin
      int rp;
      rp = 8 + 2 * $urandom_range(0, 4);
      vecs.push_back(mk(8'($urandom_range(0, 255)), rp, rp,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 0, 1, 1, 1, 0, 0));
    end

    // Reset state
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs", {data_valid, par_err, stop_err, start_glitch, busy}, 0);
      chk("rst_p_data", p_data, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);

    // Table-driven frames
    foreach (vecs[i]) run_vec(vecs[i]);

    // Start glitch: two-clock low pulse on an idle line
    @(posedge clk); #1;
    prescale = 6'd8; par_en = 1'b0; stop_bits2 = 1'b0;
    dv0 = dv_n; sg0 = sg_n;
    rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    chk("glitch_sg_count", sg_n - sg0, 1);
    chk("glitch_sg_edge", sg_cyc - start_cyc, 6);
    chk("glitch_dv_count", dv_n - dv0, 0);
    chk("glitch_busy", busy, 0);

    // Back-to-back 8N1 frames 0x00 then 0xFF
    v = mk(8'h00, 8, 8, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    set_cfg(v);
    dv0 = dv_n;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    last_good = 8'hFF;
    send_frame(v);
    v.data = 8'hFF;
    send_frame(v);
    repeat (16) @(posedge clk);
    #1;
    chk("b2b_dv_count", dv_n - dv0, 2);
    chk("b2b_spacing", dv_cyc - dv_prev, 80);
    chk("b2b_p_data", p_data, 8'hFF);

    // Reset in the middle of DATA
    prescale = 6'd8; par_en = 1'b0; stop_bits2 = 1'b0;
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    rst = 1'b0;
    rx_in = 1'b1;
    last_good = 8'h00;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_outs", {data_valid, par_err, stop_err, start_glitch, busy}, 0);
    end
    chk("midrst_p_data", p_data, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    dv0 = dv_n; pe0 = pe_n; se0 = se_n; sg0 = sg_n;
    repeat (24) @(posedge clk);
    #1;
    chk("postrst_quiet", (dv_n - dv0) + (pe_n - pe0) + (se_n - se0) + (sg_n - sg0), 0);

    // Next frame: prescale moves to 16 mid-DATA, latched 8 must be used
    v = mk(8'h96, 8, 8, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    v.chg_bit = 3;
    run_vec(v);

    chk("sb_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
